// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Sample indices and tick divisor are derived from the oversample rate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DEF_OVERSAMPLE = 16;

  function automatic int vote_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int vote_mid(input int os);
    return os / 2;
  endfunction

  function automatic int vote_hi(input int os);
    return os / 2 + 1;
  endfunction

  function automatic int last_sample(input int os);
    return os - 1;
  endfunction

  function automatic int tick_div(
    input int clk_freq,
    input int baud,
    input int os
  );
    return clk_freq / (baud * os);
  endfunction

  localparam int VOTE_LO     = vote_lo(DEF_OVERSAMPLE);
  localparam int VOTE_MID    = vote_mid(DEF_OVERSAMPLE);
  localparam int VOTE_HI     = vote_hi(DEF_OVERSAMPLE);
  localparam int LAST_SAMPLE = last_sample(DEF_OVERSAMPLE);

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle pulse every TICK_DIV clocks.
// align restarts the period so the sample phase follows an external edge.
module uart_tick_gen #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic align,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !align && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (align || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 oversampling UART receiver with start qualification,
// 2-of-3 bit voting, stop-bit check and byte/framing strobes.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TDIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW   = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_LO   = SW'(vote_lo(OVERSAMPLE));
  localparam logic [SW-1:0] S_MID  = SW'(vote_mid(OVERSAMPLE));
  localparam logic [SW-1:0] S_HI   = SW'(vote_hi(OVERSAMPLE));
  localparam logic [SW-1:0] S_LAST = SW'(last_sample(OVERSAMPLE));

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          tick;
  logic          align;

  rx_state_t     state, state_n;
  logic [SW-1:0] s_q, s_n;
  logic [2:0]    b_q, b_n;
  logic [7:0]    sh_q, sh_n;
  logic [1:0]    v_q, v_n;
  logic [7:0]    byte_q, byte_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;

  logic          vote;
  logic          at_hi;
  logic          at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  assign rx_s = sync_q[1];

  uart_tick_gen #(
    .TICK_DIV(TDIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .align(align),
    .tick (tick)
  );

  assign vote = (v_q[0] & v_q[1])
              | (v_q[0] & rx_s)
              | (v_q[1] & rx_s);

  assign at_hi   = tick && (s_q == S_HI);
  assign at_last = tick && (s_q == S_LAST);

  always_comb begin
    state_n = state;
    s_n     = s_q;
    b_n     = b_q;
    sh_n    = sh_q;
    v_n     = v_q;
    byte_n  = byte_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    align   = 1'b0;

    if (tick) begin
      s_n = s_q + SW'(1);
      if (s_q == S_LO) v_n[0] = rx_s;
      if (s_q == S_MID) v_n[1] = rx_s;
    end

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
          align   = 1'b1;
        end
      end
      START: begin
        // a start bit that votes high was only a glitch
        if (at_hi && vote) begin
          state_n = IDLE;
        end else if (at_last) begin
          state_n = DATA;
          b_n     = '0;
        end
      end
      DATA: begin
        if (at_hi) sh_n = {vote, sh_q[7:1]};
        if (at_last) begin
          if (b_q == 3'd7) state_n = STOP;
          else b_n = b_q + 3'd1;
        end
      end
      STOP: begin
        // leave mid stop bit so a back-to-back start edge is seen
        if (at_hi) begin
          if (vote) begin
            byte_n  = sh_q;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      v_q     <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_n;
      s_q     <= s_n;
      b_q     <= b_n;
      sh_q    <= sh_n;
      v_q     <= v_n;
      byte_q  <= byte_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frames plus random 8N1 traffic
// checked against an expected-event queue built from frame contents.
module tb_uart_rx_framer;

  // faster baud keeps the run short; bit period stays 16 ticks
  localparam int CLKF = 100_000_000;
  localparam int BAUD = 500_000;
  localparam int OS   = 16;
  localparam int TDIV = CLKF / (BAUD * OS);
  localparam int BIT  = OS * TDIV;
  localparam int PFAST = (BIT * 97 + 50) / 100;
  localparam int PSLOW = (BIT * 103 + 50) / 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int n_ferr = 0;
  int vcyc[$];
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  uart_rx_framer #(
    .CLK_FREQ  (CLKF),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_good(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
    last_good = d;
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, last_good});
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(
    input logic [7:0] d,
    input int         per,
    input logic       stop
  );
    uart_rx  = 1'b0;
    edge_cyc = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (per) @(negedge clk);
    end
    uart_rx = stop;
    repeat (per) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      chk("exclusive", {31'b0, rx_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("event_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      end else begin
        chk(frame_err ? "ferr_event" : "byte_event",
            {23'b0, frame_err, rx_byte}, {23'b0, exp_q.pop_front()});
      end
      if (rx_valid) begin
        chk("valid_width", {31'b0, prev_v}, 32'd0);
        vcyc.push_back(cyc);
      end
      if (frame_err) begin
        chk("ferr_width", {31'b0, prev_e}, 32'd0);
        n_ferr++;
      end
    end
    prev_v = rx_valid;
    prev_e = frame_err;
  end

  initial begin
    int lat;
    int f0;
    int i;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", {24'b0, rx_byte}, 32'd0);
    chk("rst_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    idle(BIT);

    vcyc.delete();
    push_good(8'hA5);
    send(8'hA5, BIT, 1'b1);
    chk("a5_busy", {31'b0, busy}, 32'd0);
    chk("a5_count", vcyc.size(), 32'd1);
    if (vcyc.size() > 0) begin
      lat = vcyc[0] - edge_cyc;
      chk("a5_latency",
          {31'b0, (lat >= 9 * BIT + BIT / 2) &&
                  (lat <= 9 * BIT + (11 * BIT) / 16 + 4)}, 32'd1);
    end
    idle(BIT);

    vcyc.delete();
    push_good(8'h00);
    push_good(8'hFF);
    send(8'h00, BIT, 1'b1);
    send(8'hFF, BIT, 1'b1);
    idle(BIT);
    chk("b2b_count", vcyc.size(), 32'd2);
    if (vcyc.size() == 2) chk("b2b_gap", vcyc[1] - vcyc[0], 10 * BIT);

    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    chk("glitch_busy", {31'b0, busy}, 32'd1);
    for (i = 0; i < BIT; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("glitch_idle", {31'b0, busy}, 32'd0);
    chk("glitch_byte", {24'b0, rx_byte}, 32'hFF);
    idle(BIT);

    f0 = n_ferr;
    push_err();
    send(8'h3C, BIT, 1'b0);
    repeat (19 * BIT) @(negedge clk);
    chk("break_busy", {31'b0, busy}, 32'd1);
    chk("break_byte", {24'b0, rx_byte}, 32'hFF);
    chk("break_ferrs", n_ferr - f0, 32'd1);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_idle", {31'b0, busy}, 32'd0);
    idle(BIT);
    push_good(8'h11);
    send(8'h11, BIT, 1'b1);
    idle(BIT);

    uart_rx = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_byte", {24'b0, rx_byte}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, rx_valid}, 32'd0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(5 * BIT);
    push_good(8'h5A);
    send(8'h5A, BIT, 1'b1);
    idle(BIT);
    chk("after_rst_byte", {24'b0, rx_byte}, 32'h5A);

    f0 = n_ferr;
    push_good(8'hC3);
    send(8'hC3, PSLOW, 1'b1);
    idle(BIT);
    push_good(8'hC3);
    send(8'hC3, PFAST, 1'b1);
    idle(BIT);
    chk("tol_ferrs", n_ferr - f0, 32'd0);
    chk("tol_byte", {24'b0, rx_byte}, 32'hC3);

    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       good;
      int         per;
      d    = 8'($urandom);
      per  = PFAST + int'($urandom_range(0, PSLOW - PFAST));
      good = ($urandom_range(0, 4) != 0);
      if (good) push_good(d);
      else push_err();
      send(d, per, good);
      if (!good) begin
        repeat (int'($urandom_range(0, 2)) * BIT) @(negedge clk);
        idle(BIT);
      end
      idle(int'($urandom_range(0, BIT)));
    end

    idle(2 * BIT);
    chk("pending_events", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
